tag_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the tag cache's memory port.
- Accepts burst read and write requests from the cache's memory interface and serves them from an internal word array.
- Returns read data beats and write acknowledgements.
- Used in cache_env as the RTL stand-in for the behavioural memory, so cache refill and writeback traffic runs against real handshake timing.

---
 rtl/tag_mem_responder.sv | 104 ++++++++++
 tb/tb_tag_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tag_mem_responder.sv
// tag_mem_responder: memory-side responder serving burst reads and writes from an internal word array,
// returning read beats and write acknowledgements to the tag cache memory port.
module tag_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024,
    parameter int LAT        = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]              req_len,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_last,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic                    b_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(NB);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WRESP} state_t;

    state_t                state, next;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [IW-1:0]         idx, idx_nx;
    logic [8:0]            left;
    logic [LW-1:0]         cnt;
    logic                  err;
    logic                  req_hs, w_hs, r_hs, b_hs, final_beat;

    assign req_ready  = state == IDLE;
    assign w_ready    = state == WDATA;
    assign r_valid    = state == RDATA;
    assign b_valid    = state == WRESP;
    assign final_beat = left == 9'd1;
    assign r_last     = r_valid && final_beat;
    assign b_err      = b_valid && err;
    assign req_hs     = req_valid && req_ready;
    assign w_hs       = w_valid && w_ready;
    assign r_hs       = r_valid && r_ready;
    assign b_hs       = b_valid && b_ready;
    assign idx_nx     = idx + IW'(1);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (req_hs) next = req_write ? WDATA : RWAIT;
            RWAIT:   if (cnt == '0) next = RDATA;
            RDATA:   if (r_hs && final_beat) next = IDLE;
            WDATA:   if (w_hs && final_beat) next = WRESP;
            WRESP:   if (b_hs) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // r_data is registered: loaded as RWAIT expires and refilled with the next word on each read handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx    <= '0;
            left   <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            r_data <= '0;
        end else begin
            if (req_hs) begin
                idx  <= req_addr[BW +: IW];
                left <= {1'b0, req_len} + 9'd1;
                cnt  <= LW'(LAT - 1);
                err  <= 1'b0;
            end
            if (state == RWAIT && cnt != '0) cnt <= cnt - LW'(1);
            if (state == RWAIT && cnt == '0) r_data <= mem[idx];
            if (r_hs || w_hs) begin
                idx  <= idx_nx;
                left <= left - 9'd1;
            end
            if (r_hs) r_data <= final_beat ? '0 : mem[idx_nx];
            if (w_hs && (w_last != final_beat)) err <= 1'b1;
            if (b_hs) err <= 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (w_hs)
            for (int i = 0; i < NB; i++)
                if (w_strb[i]) mem[idx][i*8 +: 8] <= w_data[i*8 +: 8];
endmodule

// File: tb/tb_tag_mem_responder.sv
// tb_tag_mem_responder: randomized bursts against a word-array reference model with
// directed cases for latency, stalls, wrap, strobes, framing errors and mid-burst reset.
module tb_tag_mem_responder;
    localparam int LAT = 2;
    localparam int WORDS = 1024;

    logic        clk, rstn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic        b_valid, b_ready, b_err;

    tag_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_WORDS(WORDS), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err)
    );

    always #5 clk = ~clk;

    logic [63:0] mem_m [WORDS];
    logic [63:0] wd [$];
    logic [7:0]  ws [$];
    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] s);
        wd.push_back(d);
        ws.push_back(s);
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 3) & 32'h3FF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lastpos: beat carrying w_last (len+1 means none); framing is wrong unless lastpos == len
    task automatic wr(input logic [31:0] addr, input int len, input int lastpos);
        int base;
        logic [63:0] d;
        logic [7:0] s;
        base = word_of(addr);
        check("wr req_ready", req_ready, 1);
        req_valid = 1; req_write = 1; req_addr = addr; req_len = 8'(len);
        tick();
        req_valid = 0; req_addr = $urandom;
        for (int i = 0; i <= len; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                w_valid = 0;
                tick();
            end
            d = wd[i];
            s = ws[i];
            w_valid = 1; w_data = d; w_strb = s; w_last = (i == lastpos);
            check("w_ready", w_ready, 1);
            tick();
            for (int b = 0; b < 8; b++)
                if (s[b]) mem_m[(base + i) % WORDS][b*8 +: 8] = d[b*8 +: 8];
        end
        w_data = {$urandom, $urandom}; w_strb = 8'hFF; w_last = 1;
        check("b_valid", b_valid, 1);
        check("b_err", b_err, 64'(lastpos != len));
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("b_valid hold", b_valid, 1);
            check("b_err hold", b_err, 64'(lastpos != len));
        end
        b_ready = 1;
        tick();
        b_ready = 0; w_valid = 0;
        check("b_valid cleared", b_valid, 0);
        check("wr idle", req_ready, 1);
    endtask

    // smode: 0 = no stalls, 1 = r_ready toggles each cycle, 2 = random stalls
    task automatic rd(input logic [31:0] addr, input int len, input int smode);
        int base, lat, ns;
        base = word_of(addr);
        check("rd req_ready", req_ready, 1);
        req_valid = 1; req_write = 0; req_addr = addr; req_len = 8'(len);
        tick();
        req_valid = 0; r_ready = 1;
        w_valid = 1; w_data = {$urandom, $urandom}; w_strb = 8'hFF;
        lat = 0;
        while (!r_valid && lat < 20) begin
            tick();
            lat++;
        end
        r_ready = 0;
        check("rd latency", lat, LAT);
        for (int i = 0; i <= len; i++) begin
            ns = (smode == 0) ? 0 : (smode == 1) ? 1 : $urandom_range(0, 2);
            for (int k = 0; k <= ns; k++) begin
                check("r_valid", r_valid, 1);
                check("r_data", r_data, mem_m[(base + i) % WORDS]);
                check("r_last", r_last, 64'(i == len));
                if (k < ns) tick();
            end
            r_ready = 1;
            tick();
            r_ready = 0;
        end
        w_valid = 0;
        check("rd done r_valid", r_valid, 0);
        check("rd done req_ready", req_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        int len, n;
        clk = 0; rstn = 0;
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        r_ready = 0; b_ready = 0;
        #12;
        check("rst req_ready", req_ready, 1);
        check("rst w_ready", w_ready, 0);
        check("rst r_valid", r_valid, 0);
        check("rst r_last", r_last, 0);
        check("rst b_valid", b_valid, 0);
        check("rst b_err", b_err, 0);
        check("rst r_data", r_data, 0);
        @(negedge clk);
        rstn = 1;
        tick();

        for (int k = 0; k < 4; k++) begin
            wd.delete(); ws.delete();
            for (int i = 0; i < 256; i++) push({$urandom, $urandom}, 8'hFF);
            wr(32'(k * 2048), 255, 255);
        end

        wd.delete(); ws.delete();
        for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i), 8'hFF);
        wr(32'h100, 3, 3);
        rd(32'h100, 3, 0);
        rd(32'h100, 1, 1);

        wd.delete(); ws.delete();
        push(64'h11, 8'hFF); push(64'h22, 8'hFF);
        wr(32'((WORDS - 1) * 8), 1, 1);
        rd(32'((WORDS - 1) * 8), 1, 0);
        rd(32'h0, 0, 0);

        wd.delete(); ws.delete();
        push(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(32'h200, 0, 0);
        wd.delete(); ws.delete();
        push(64'h0, 8'h0F);
        wr(32'h205, 0, 0);
        rd(32'h200, 0, 0);

        wd.delete(); ws.delete();
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 8'hFF);
        wr(32'h300, 2, 1);
        wd.delete(); ws.delete();
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 8'hFF);
        wr(32'h300, 2, 2);
        rd(32'h300, 2, 2);

        req_valid = 1; req_write = 0; req_addr = 32'h100; req_len = 8'd7;
        tick();
        req_valid = 0;
        n = 0;
        while (!r_valid && n < 20) begin
            tick();
            n++;
        end
        r_ready = 1;
        repeat (2) tick();
        r_ready = 0;
        check("pre-reset r_valid", r_valid, 1);
        check("pre-reset r_data", r_data, mem_m[34]);
        #2 rstn = 0;
        #1;
        check("abort req_ready", req_ready, 1);
        check("abort r_valid", r_valid, 0);
        check("abort r_last", r_last, 0);
        check("abort r_data", r_data, 0);
        check("abort b_valid", b_valid, 0);
        check("abort w_ready", w_ready, 0);
        @(negedge clk);
        rstn = 1;
        tick();
        rd(32'h100, 7, 2);
        rd(32'((WORDS - 8) * 8), 255, 2);

        repeat (60) begin
            addr = $urandom;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                wd.delete(); ws.delete();
                for (int i = 0; i <= len; i++) push({$urandom, $urandom}, 8'($urandom));
                wr(addr, len, ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len);
            end else begin
                rd(addr, len, 2);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
